// File: rtl/i2s_audio_rx_if.sv
// ---------------------------------------------------------------------------
// i2s_audio_rx_if
//   Bundles the serial audio pins and the parallel sample output of the
//   I2S receiver.
//   modport slave  : the receiver (samples the pins, drives the sample bus)
//   modport master : the audio source / sample consumer side
//   Signals:
//     i2s_bck       serial bit clock, asynchronous to the system clock
//     i2s_ws        word select: 0 left slot, 1 right slot
//     i2s_sd        serial data, MSB first, two's complement
//     audio_sample  last captured sample, MSB-aligned, A bits
//     sample_valid  one-clk pulse when audio_sample updates
//     frame_err     sticky short-slot flag
// ---------------------------------------------------------------------------
interface i2s_audio_rx_if #(
    parameter int A = 8
);
    logic         i2s_bck;
    logic         i2s_ws;
    logic         i2s_sd;
    logic [A-1:0] audio_sample;
    logic         sample_valid;
    logic         frame_err;

    modport master (
        output i2s_bck, i2s_ws, i2s_sd,
        input  audio_sample, sample_valid, frame_err
    );

    modport slave (
        input  i2s_bck, i2s_ws, i2s_sd,
        output audio_sample, sample_valid, frame_err
    );
endinterface

// File: rtl/i2s_audio_rx.sv
// ---------------------------------------------------------------------------
// i2s_audio_rx
//   I2S / left-justified serial audio receiver in the system clock domain.
//   Oversamples BCK/WS/SD, keeps the A MSBs of the selected channel's slot and
//   emits one parallel sample per stereo frame.
//   Optional feature macro: I2S_FRAME_ERR_EN (sticky short-slot detection on
//   frame_err); when undefined frame_err is tied low.
//   Ports:
//     clk             system clock (f_bck <= f_clk/4)
//     rst_n           asynchronous active-low reset
//     ena             1: receive, 0: hold FSM in IDLE
//     i2s_ws_align    0: standard I2S (MSB one BCK after WS edge), 1: left-justified
//     audio_chan_sel  0: output left channel, 1: output right channel
//     bus             i2s_audio_rx_if.slave (pins in, sample/valid/frame_err out)
//   Latency: SYNC_STAGES+2 clk from pin BCK rise to audio_sample/sample_valid.
// ---------------------------------------------------------------------------
module i2s_audio_rx #(
    parameter int A           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          i2s_ws_align,
    input  logic          audio_chan_sel,
    i2s_audio_rx_if.slave bus
);
    localparam int CNT_W = $clog2(A + 1);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Pin synchronisers plus one aligned sampling stage: rise, ws_s and
    // sd_s all describe the same BCK rising edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bck_sync, ws_sync, sd_sync;
    logic                   bck_prev, rise, ws_s, sd_s;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            bck_prev <= 1'b0;
            rise     <= 1'b0;
            ws_s     <= 1'b0;
            sd_s     <= 1'b0;
        end else begin
            bck_sync <= {bck_sync[SYNC_STAGES-2:0], bus.i2s_bck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], bus.i2s_ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], bus.i2s_sd};
            bck_prev <= bck_sync[SYNC_STAGES-1];
            rise     <= bck_sync[SYNC_STAGES-1] & ~bck_prev;
            ws_s     <= ws_sync[SYNC_STAGES-1];
            sd_s     <= sd_sync[SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Slot tracking. In standard I2S the bit sampled at an edge belongs to
    // the channel WS showed one BCK earlier. 'seen' counts rises since the
    // last resync so a slot boundary is only trusted once the history it
    // depends on was really observed (1 rise for LJ, 2 for I2S).
    // ------------------------------------------------------------------
    logic       ws_d, slot_ws, slot_ws_prev;
    logic [1:0] seen;
    logic       hist_ok, slot_start, abort;
    logic       sel_q, align_q;

    assign slot_ws    = i2s_ws_align ? ws_s : ws_d;
    assign hist_ok    = i2s_ws_align ? (seen != 2'd0) : (seen == 2'd2);
    assign slot_start = rise & hist_ok & (slot_ws != slot_ws_prev);
    assign abort      = ~ena | (audio_chan_sel != sel_q) | (i2s_ws_align != align_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_d         <= 1'b0;
            slot_ws_prev <= 1'b0;
            seen         <= 2'd0;
            sel_q        <= 1'b0;
            align_q      <= 1'b0;
        end else begin
            sel_q   <= audio_chan_sel;
            align_q <= i2s_ws_align;
            if (abort)
                seen <= 2'd0;
            else if (rise && seen != 2'd2)
                seen <= seen + 2'd1;
            if (rise) begin
                ws_d         <= ws_s;
                slot_ws_prev <= slot_ws;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic load, shift, emit;
    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (slot_start) begin
            case (state)
                IDLE:    state_nxt = (slot_ws == audio_chan_sel) ? CAPTURE : SKIP;
                SKIP:    if (slot_ws == audio_chan_sel) state_nxt = CAPTURE;
                CAPTURE: state_nxt = SKIP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        emit  = 1'b0;
        if (!abort) begin
            case (state)
                IDLE, SKIP: load = slot_start && (slot_ws == audio_chan_sel);
                CAPTURE: begin
                    // The edge that ends the slot carries the other channel's
                    // first bit, so it is never shifted in.
                    emit  = slot_start;
                    shift = rise && !slot_start && (bit_cnt < CNT_W'(A));
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [A-1:0]     shreg, sample_q;
    logic             valid_q;
    logic [CNT_W-1:0] pad_amt;

    // Short slots are left-aligned by zero-padding the LSBs.
    assign pad_amt = CNT_W'(A) - bit_cnt;

    // NOTE: the shift register is reset along with the control state even
    // though load overwrites it; this keeps the whole datapath at a known
    // value out of reset at negligible cost for an A-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= emit;
            if (load) begin
                shreg   <= {{(A-1){1'b0}}, sd_s};
                bit_cnt <= CNT_W'(1);
            end else if (shift) begin
                shreg   <= {shreg[A-2:0], sd_s};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (emit)
                sample_q <= shreg << pad_amt;
        end
    end

    assign bus.audio_sample = sample_q;
    assign bus.sample_valid = valid_q;

`ifdef I2S_FRAME_ERR_EN
    // Any emitted slot shorter than A bits (including a zero-bit one) marks
    // the stream as malformed until the next reset.
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err_q <= 1'b0;
        else if (emit && bit_cnt < CNT_W'(A))
            frame_err_q <= 1'b1;
    end

    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_audio_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2s_audio_rx
//   Drives serial audio streams into i2s_audio_rx and compares the emitted
//   samples against a stream-level reference model: slots are found as runs of
//   the channel owning each bit, and every selected slot whose start and end
//   are both observed yields its first A bits, MSB-aligned.
// ---------------------------------------------------------------------------
module tb_i2s_audio_rx;
    localparam int A        = 8;
    localparam int SYNC     = 2;
    localparam int HALF_BCK = 33;
`ifdef I2S_FRAME_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic align = 1'b0;
    logic sel   = 1'b0;

    i2s_audio_rx_if #(.A(A)) bus ();

    i2s_audio_rx #(.A(A), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .i2s_ws_align  (align),
        .audio_chan_sel(sel),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic         ws_q[$];
    logic         sd_q[$];
    logic [31:0]  l_words[$];
    logic [31:0]  r_words[$];
    logic [A-1:0] exp_q[$];
    logic [A-1:0] got_q[$];
    bit           exp_err;
    int           n_vec = 0;
    int           n_bad = 0;

    always @(negedge clk)
        if (rst_n && bus.sample_valid === 1'b1)
            got_q.push_back(bus.audio_sample);

    // --------------------------------------------------------------------
    // Stream construction, playback and reference model
    // --------------------------------------------------------------------
    task automatic build(input int width, input bit align_tx);
        logic lj[$];
        ws_q.delete();
        sd_q.delete();
        for (int f = 0; f < l_words.size(); f++) begin
            for (int i = width - 1; i >= 0; i--) begin
                lj.push_back(1'b0);
                sd_q.push_back(l_words[f][i]);
            end
            for (int i = width - 1; i >= 0; i--) begin
                lj.push_back(1'b1);
                sd_q.push_back(r_words[f][i]);
            end
        end
        // Standard I2S moves WS one bit ahead of the data it describes.
        for (int k = 0; k < lj.size(); k++)
            ws_q.push_back(align_tx ? lj[k] : ((k + 1 < lj.size()) ? lj[k + 1] : 1'b0));
    endtask

    task automatic play(input int from, input int to);
        for (int k = from; k < to; k++) begin
            bus.i2s_ws = ws_q[k];
            bus.i2s_sd = sd_q[k];
            #HALF_BCK bus.i2s_bck = 1'b1;
            #HALF_BCK bus.i2s_bck = 1'b0;
        end
    endtask

    // Appends the samples a receiver that starts observing at bit 'from'
    // must emit for bits [from, to).
    task automatic model(input int from, input int to, input bit align_rx, input bit sel_rx);
        int           rs, len;
        bit           cur, sw, sp;
        logic [A-1:0] v;
        rs  = -1;
        cur = 1'b0;
        for (int k = from + (align_rx ? 1 : 2); k < to; k++) begin
            sw = align_rx ? ws_q[k]     : ws_q[k - 1];
            sp = align_rx ? ws_q[k - 1] : ws_q[k - 2];
            if (sw != sp) begin
                if (rs >= 0 && cur == sel_rx) begin
                    len = k - rs;
                    v   = '0;
                    for (int i = 0; i < len && i < A; i++)
                        v[A - 1 - i] = sd_q[rs + i];
                    exp_q.push_back(v);
                    if (len < A) exp_err = 1'b1;
                end
                rs  = k;
                cur = sw;
            end
        end
    endtask

    task automatic do_reset();
        bus.i2s_bck = 1'b0;
        bus.i2s_ws  = 1'b0;
        bus.i2s_sd  = 1'b0;
        rst_n = 1'b0;
        #23 rst_n = 1'b1;
        #40;
        got_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic set_frames(input int n, input logic [31:0] l, input logic [31:0] r);
        l_words.delete();
        r_words.delete();
        for (int f = 0; f < n; f++) begin
            l_words.push_back(l);
            r_words.push_back(r);
        end
    endtask

    // --------------------------------------------------------------------
    // Scenarios
    // --------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        #1;
        n_vec++;
        if (bus.audio_sample !== '0) begin
            n_bad++; $display("FAIL reset_sample: got %h expected 00", bus.audio_sample);
        end
        n_vec++;
        if (bus.sample_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.sample_valid);
        end
        n_vec++;
        if (bus.frame_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err);
        end
        do_reset();
    endtask

    task automatic test_i2s_left();
        align = 1'b0; sel = 1'b0;
        do_reset();
        set_frames(4, 32'hA5C3, 32'h1234);
        build(16, 1'b0);
        model(0, ws_q.size(), 1'b0, 1'b0);
        play(0, ws_q.size());
        #300;
        n_vec++;
        if (got_q.size() !== 3) begin
            n_bad++; $display("FAIL i2s_left_count: got %0d expected 3", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== 8'hA5) begin
                n_bad++; $display("FAIL i2s_left_sample[%0d]: got %h expected a5", i, got_q[i]);
            end
        end
        n_vec++;
        if (bus.frame_err !== (FE_EN & exp_err)) begin
            n_bad++; $display("FAIL i2s_left_frame_err: got %b expected %b", bus.frame_err, FE_EN & exp_err);
        end
    endtask

    task automatic test_i2s_right();
        align = 1'b0; sel = 1'b1;
        do_reset();
        set_frames(4, 32'hA5C3, 32'h1234);
        build(16, 1'b0);
        // Start mid right slot of the first frame: that slot is partial.
        model(20, ws_q.size(), 1'b0, 1'b1);
        play(20, ws_q.size());
        #300;
        n_vec++;
        if (got_q.size() !== 2) begin
            n_bad++; $display("FAIL i2s_right_count: got %0d expected 2", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== 8'h12) begin
                n_bad++; $display("FAIL i2s_right_sample[%0d]: got %h expected 12", i, got_q[i]);
            end
        end
    endtask

    task automatic test_align();
        for (int m = 0; m < 2; m++) begin
            logic [A-1:0] want;
            want  = (m == 0) ? 8'h81 : 8'h02;
            align = (m == 0);
            sel   = 1'b0;
            do_reset();
            set_frames(4, 32'h8100, 32'h7F3C);
            build(16, 1'b1);
            model(0, ws_q.size(), align, 1'b0);
            play(0, ws_q.size());
            #300;
            n_vec++;
            if (got_q.size() !== exp_q.size() || got_q.size() == 0) begin
                n_bad++; $display("FAIL align%0d_count: got %0d expected %0d", m, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== want) begin
                    n_bad++; $display("FAIL align%0d_sample[%0d]: got %h expected %h", m, i, got_q[i], want);
                end
            end
        end
    endtask

    task automatic test_short_slots();
        align = 1'b0; sel = 1'b0;
        do_reset();
        set_frames(5, 32'hB, 32'h6);
        build(4, 1'b0);
        model(0, ws_q.size(), 1'b0, 1'b0);
        play(0, ws_q.size());
        #300;
        n_vec++;
        if (got_q.size() !== exp_q.size() || got_q.size() == 0) begin
            n_bad++; $display("FAIL short_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== 8'hB0) begin
                n_bad++; $display("FAIL short_sample[%0d]: got %h expected b0", i, got_q[i]);
            end
        end
        n_vec++;
        if (bus.frame_err !== FE_EN) begin
            n_bad++; $display("FAIL short_frame_err: got %b expected %b", bus.frame_err, FE_EN);
        end
    endtask

    task automatic test_reset_mid();
        align = 1'b0; sel = 1'b0;
        do_reset();
        set_frames(5, 32'hA5C3, 32'h1234);
        build(16, 1'b0);
        model(0, 72, 1'b0, 1'b0);
        play(0, 72);
        #10 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.audio_sample !== '0 || bus.sample_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_outputs: got %h/%b/%b expected 00/0/0",
                              bus.audio_sample, bus.sample_valid, bus.frame_err);
        end
        #20 rst_n = 1'b1;
        #20;
        exp_err = 1'b0;
        model(72, ws_q.size(), 1'b0, 1'b0);
        play(72, ws_q.size());
        #300;
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL reset_mid_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL reset_mid_sample[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        for (int m = 0; m < 2; m++) begin
            align = 1'b0; sel = 1'b0; ena = 1'b1;
            do_reset();
            set_frames(6, 32'hA5C3, 32'h1234);
            build(16, 1'b0);
            model(0, 72, 1'b0, 1'b0);
            play(0, 72);
            #15;
            if (m == 0) begin
                sel = 1'b1;
                model(72, ws_q.size(), 1'b0, 1'b1);
                play(72, ws_q.size());
            end else begin
                ena = 1'b0;
                play(72, 88);
                #15 ena = 1'b1;
                model(88, ws_q.size(), 1'b0, 1'b0);
                play(88, ws_q.size());
            end
            #300;
            n_vec++;
            if (got_q.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL abort%0d_count: got %0d expected %0d", m, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL abort%0d_sample[%0d]: got %h expected %h", m, i, got_q[i], exp_q[i]);
                end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int width, offset;
            width = $urandom_range(20, 4);
            align = $urandom_range(1, 0);
            sel   = $urandom_range(1, 0);
            do_reset();
            l_words.delete();
            r_words.delete();
            for (int f = 0; f < 4; f++) begin
                l_words.push_back($urandom);
                r_words.push_back($urandom);
            end
            build(width, align);
            offset = $urandom_range(2 * width - 1, 0);
            model(offset, ws_q.size(), align, sel);
            play(offset, ws_q.size());
            #300;
            n_vec++;
            if (got_q.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL rand%0d_count: w=%0d got %0d expected %0d", it, width, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL rand%0d_sample[%0d]: got %h expected %h", it, i, got_q[i], exp_q[i]);
                end
            end
            n_vec++;
            if (bus.frame_err !== (FE_EN & exp_err)) begin
                n_bad++; $display("FAIL rand%0d_frame_err: got %b expected %b", it, bus.frame_err, FE_EN & exp_err);
            end
        end
    endtask

    initial begin
        bus.i2s_bck = 1'b0;
        bus.i2s_ws  = 1'b0;
        bus.i2s_sd  = 1'b0;
        test_reset();
        test_i2s_left();
        test_i2s_right();
        test_align();
        test_short_slots();
        test_reset_mid();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
